// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared types, opcodes and latch layouts for the decode stage
package decode_stage_pkg;

    localparam int DBITS    = 32;
    localparam int INSTBITS = 32;
    localparam int REGNO    = 32;
    localparam int REGBITS  = 5;
    localparam int SBBITS   = 2;

    typedef enum logic [3:0] {
        OPC_INVALID = 4'd0,
        OPC_ALU_R   = 4'd1,
        OPC_ALU_I   = 4'd2,
        OPC_LOAD    = 4'd3,
        OPC_STORE   = 4'd4,
        OPC_BRANCH  = 4'd5,
        OPC_JAL     = 4'd6,
        OPC_JALR    = 4'd7,
        OPC_LUI     = 4'd8,
        OPC_AUIPC   = 4'd9
    } op_class_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_ALU_R  = 7'b0110011;

    // Field order is MSB first, matching the flat latch vectors on the ports.
    typedef struct packed {
        logic                valid;
        logic [INSTBITS-1:0] inst;
        logic [DBITS-1:0]    pc;
        logic [DBITS-1:0]    pcplus;
        logic [DBITS-1:0]    inst_count;
    } fe_latch_t;

    typedef struct packed {
        logic                valid;
        logic [INSTBITS-1:0] inst;
        logic [DBITS-1:0]    pc;
        logic [DBITS-1:0]    pcplus;
        logic [DBITS-1:0]    inst_count;
        op_class_t           op_class;
        logic [REGBITS-1:0]  rd;
        logic [DBITS-1:0]    rs1_val;
        logic [DBITS-1:0]    rs2_val;
        logic [DBITS-1:0]    imm;
        logic                wr_reg;
    } de_latch_t;

    localparam int FE_LATCH_W = $bits(fe_latch_t);
    localparam int DE_LATCH_W = $bits(de_latch_t);

    function automatic op_class_t classify(input logic [6:0] opcode);
        case (opcode)
            OP_ALU_R:  return OPC_ALU_R;
            OP_ALU_I:  return OPC_ALU_I;
            OP_LOAD:   return OPC_LOAD;
            OP_STORE:  return OPC_STORE;
            OP_BRANCH: return OPC_BRANCH;
            OP_JAL:    return OPC_JAL;
            OP_JALR:   return OPC_JALR;
            OP_LUI:    return OPC_LUI;
            OP_AUIPC:  return OPC_AUIPC;
            default:   return OPC_INVALID;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_scoreboard.sv
// rtl/decode_stage_scoreboard.sv - per-register in-flight writer counters for RAW detection
module decode_stage_scoreboard
    import decode_stage_pkg::*;
#(
    parameter int REGNO   = decode_stage_pkg::REGNO,
    parameter int REGBITS = decode_stage_pkg::REGBITS,
    parameter int SBBITS  = decode_stage_pkg::SBBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REGBITS-1:0] rs1,
    input  logic [REGBITS-1:0] rs2,
    input  logic               inc,
    input  logic [REGBITS-1:0] inc_rd,
    input  logic               wb_we,
    input  logic [REGBITS-1:0] wb_rd,
    output logic               busy1,
    output logic               busy2
);

    logic [REGNO-1:0][SBBITS-1:0] cnt;
    logic                         dec;

    assign dec = wb_we && (wb_rd != '0);

    // A writer retiring this cycle no longer counts, so its readers can use the bypass.
    function automatic logic eff_busy(input logic [REGBITS-1:0] r);
        logic [SBBITS-1:0] hit;
        if (r == '0)
            return 1'b0;
        hit = SBBITS'(wb_we && (wb_rd == r));
        return (cnt[r] - hit) != '0;
    endfunction

    assign busy1 = eff_busy(rs1);
    assign busy2 = eff_busy(rs2);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            for (int r = 1; r < REGNO; r++) begin
                if (inc && (inc_rd == REGBITS'(r)) && !(dec && (wb_rd == REGBITS'(r))))
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dec && (wb_rd == REGBITS'(r)) && !(inc && (inc_rd == REGBITS'(r))))
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (inc && !(dec && (wb_rd == inc_rd)))
                assert (cnt[inc_rd] != '1) else $error("scoreboard overflow on x%0d", inc_rd);
            if (dec && !(inc && (inc_rd == wb_rd)))
                assert (cnt[wb_rd] != '0) else $error("scoreboard underflow on x%0d", wb_rd);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - FE latch consumer: decode, register read, hazard stall, DE latch
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DBITS    = decode_stage_pkg::DBITS,
    parameter int INSTBITS = decode_stage_pkg::INSTBITS,
    parameter int REGNO    = decode_stage_pkg::REGNO,
    parameter int REGBITS  = decode_stage_pkg::REGBITS,
    parameter int SBBITS   = decode_stage_pkg::SBBITS
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [1+INSTBITS+3*DBITS-1:0]              fe_latch_in,
    input  logic                                       agex_flush,
    input  logic                                       wb_we,
    input  logic [REGBITS-1:0]                         wb_rd,
    input  logic [DBITS-1:0]                           wb_data,
    output logic                                       stall_to_fe,
    output logic [1+INSTBITS+3*DBITS+4+REGBITS+3*DBITS:0] de_latch_out
);

    fe_latch_t          fe;
    de_latch_t          de_q;
    de_latch_t          de_next;
    op_class_t          op_class;
    logic [6:0]         opcode;
    logic [REGBITS-1:0] rd;
    logic [REGBITS-1:0] rs1;
    logic [REGBITS-1:0] rs2;
    logic [DBITS-1:0]   imm;
    logic               use_rs1;
    logic               use_rs2;
    logic               wr_reg;
    logic               busy1;
    logic               busy2;
    logic               issue;
    logic [DBITS-1:0]   rf [REGNO];

    assign fe     = fe_latch_in;
    assign opcode = fe.inst[6:0];
    assign rd     = fe.inst[11:7];
    assign rs1    = fe.inst[19:15];
    assign rs2    = fe.inst[24:20];
    assign op_class = classify(opcode);

    always_comb begin
        imm     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        wr_reg  = 1'b0;
        case (op_class)
            OPC_ALU_R:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_reg = 1'b1; end
            OPC_ALU_I, OPC_LOAD, OPC_JALR: begin
                imm = {{(DBITS-12){fe.inst[31]}}, fe.inst[31:20]};
                use_rs1 = 1'b1;
                wr_reg  = 1'b1;
            end
            OPC_STORE: begin
                imm = {{(DBITS-12){fe.inst[31]}}, fe.inst[31:25], fe.inst[11:7]};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                imm = {{(DBITS-13){fe.inst[31]}}, fe.inst[31], fe.inst[7],
                       fe.inst[30:25], fe.inst[11:8], 1'b0};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_JAL: begin
                imm = {{(DBITS-21){fe.inst[31]}}, fe.inst[31], fe.inst[19:12],
                       fe.inst[20], fe.inst[30:21], 1'b0};
                wr_reg = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm = {{(DBITS-32){fe.inst[31]}}, fe.inst[31:12], 12'b0};
                wr_reg = 1'b1;
            end
            default: ;
        endcase
        if (rd == '0)
            wr_reg = 1'b0;
    end

    // WB data is forwarded combinationally so a same-cycle retire unblocks the reader.
    function automatic logic [DBITS-1:0] read_reg(input logic [REGBITS-1:0] r);
        if (r == '0)
            return '0;
        if (wb_we && (wb_rd == r))
            return wb_data;
        return rf[r];
    endfunction

    decode_stage_scoreboard #(
        .REGNO   (REGNO),
        .REGBITS (REGBITS),
        .SBBITS  (SBBITS)
    ) u_sb (
        .clk    (clk),
        .reset  (reset),
        .rs1    (rs1),
        .rs2    (rs2),
        .inc    (issue && wr_reg),
        .inc_rd (rd),
        .wb_we  (wb_we),
        .wb_rd  (wb_rd),
        .busy1  (busy1),
        .busy2  (busy2)
    );

    assign stall_to_fe = fe.valid && !agex_flush && ((use_rs1 && busy1) || (use_rs2 && busy2));
    assign issue       = fe.valid && !agex_flush && !stall_to_fe;

    always_comb begin
        de_next = '0;
        if (issue) begin
            de_next.valid      = 1'b1;
            de_next.inst       = fe.inst;
            de_next.pc         = fe.pc;
            de_next.pcplus     = fe.pcplus;
            de_next.inst_count = fe.inst_count;
            de_next.op_class   = op_class;
            de_next.rd         = rd;
            de_next.rs1_val    = read_reg(rs1);
            de_next.rs2_val    = read_reg(rs2);
            de_next.imm        = imm;
            de_next.wr_reg     = wr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            de_q <= '0;
        else
            de_q <= de_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < REGNO; r++)
                rf[r] <= '0;
        end else if (wb_we && (wb_rd != '0)) begin
            rf[wb_rd] <= wb_data;
        end
    end

    assign de_latch_out = de_q;

endmodule
